// File: rtl/operand_fetch_seq.sv
// Sequences up to two operand reads through the single regfile read port, with write bypass and snoop coherence.
// Latency: op_valid 1 + (number of used operands) cycles after request acceptance.
// Backpressure: req_ready only in IDLE; operands held (and kept coherent) in HOLD until op_ready.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_REG
`define NUM_REG 16
`endif

module operand_fetch_seq #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_REG    = `NUM_REG,
    localparam int AW        = $clog2(NUM_REG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_src_a,
    input  logic [AW-1:0]         req_src_b,
    input  logic                  req_use_a,
    input  logic                  req_use_b,
    output logic                  rd_enable,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_enable,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [AW-1:0]         r_src_a;
    logic [AW-1:0]         r_src_b;
    logic                  r_use_a;
    logic                  r_use_b;
    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;

    // A write hitting a latched source register: bypass during its read, snoop afterwards.
    logic w_hit_a;
    logic w_hit_b;
    assign w_hit_a = wr_enable && (wr_addr == r_src_a);
    assign w_hit_b = wr_enable && (wr_addr == r_src_b);

    // Outputs decode only state and latched fields.
    assign req_ready = (r_state == IDLE);
    assign op_valid  = (r_state == HOLD);
    assign rd_enable = (r_state == READ_A) || (r_state == READ_B);
    assign rd_addr   = (r_state == READ_A) ? r_src_a :
                       (r_state == READ_B) ? r_src_b : '0;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state: skip read cycles for operands that are not needed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req_use_a)      w_next_state = READ_A;
                    else if (req_use_b) w_next_state = READ_B;
                    else                w_next_state = HOLD;
                end
            end
            READ_A:  w_next_state = r_use_b ? READ_B : HOLD;
            READ_B:  w_next_state = HOLD;
            HOLD:    if (op_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch, operand capture with bypass, and coherence snoop of captured operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_a <= '0;
            r_src_b <= '0;
            r_use_a <= 1'b0;
            r_use_b <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_src_a <= req_src_a;
                        r_src_b <= req_src_b;
                        r_use_a <= req_use_a;
                        r_use_b <= req_use_b;
                        r_op_a  <= '0;
                        r_op_b  <= '0;
                    end
                end
                READ_A: begin
                    r_op_a <= w_hit_a ? wr_data : rd_data;
                end
                READ_B: begin
                    r_op_b <= w_hit_b ? wr_data : rd_data;
                    if (w_hit_a && r_use_a) r_op_a <= wr_data;
                end
                HOLD: begin
                    if (w_hit_a && r_use_a) r_op_a <= wr_data;
                    if (w_hit_b && r_use_b) r_op_b <= wr_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Randomized and directed bench for operand_fetch_seq against a regfile array model.
// Reference: a used operand seen in HOLD always equals the current architectural register value.
// Consumer backpressure is exercised with random hold lengths before op_ready.
module tb_operand_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_src_a;
    logic [3:0]  req_src_b;
    logic        req_use_a;
    logic        req_use_b;
    logic        rd_enable;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_enable;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [16];

    operand_fetch_seq #(.DATA_WIDTH(32), .NUM_REG(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_a(req_src_a), .req_src_b(req_src_b),
        .req_use_a(req_use_a), .req_use_b(req_use_b),
        .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, write on the clock edge.
    assign rd_data = mem[rd_addr];
    always @(posedge clk) if (wr_enable) mem[wr_addr] <= wr_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the write port for one cycle: forced write at cycle fk, else optional random write.
    task automatic set_wr(input int k, input int fk, input logic [3:0] fa, input logic [31:0] fd,
                          input bit rnd, input logic [3:0] sa, input logic [3:0] sb);
        wr_enable = 1'b0;
        if (k == fk) begin
            wr_enable = 1'b1; wr_addr = fa; wr_data = fd;
        end else if (rnd && ($urandom_range(0, 1) == 1)) begin
            wr_enable = 1'b1;
            wr_data   = $urandom;
            case ($urandom_range(0, 2))
                0:       wr_addr = sa;
                1:       wr_addr = sb;
                default: wr_addr = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        wr_enable = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_enable = 1'b0;
    endtask

    // One full transaction; cycle index k: 0 accept, 1..n reads, n+1.. hold.
    task automatic txn(input logic [3:0] sa, input logic [3:0] sb, input bit ua, input bit ub,
                       input int hold, input bit rnd,
                       input int fk, input logic [3:0] fa, input logic [31:0] fd);
        int n;
        n = int'(ua) + int'(ub);
        check("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_src_a = sa; req_src_b = sb; req_use_a = ua; req_use_b = ub;
        set_wr(0, fk, fa, fd, rnd, sa, sb);
        tick();
        req_valid = 1'b0;
        req_src_a = 4'($urandom_range(0, 15)); req_src_b = 4'($urandom_range(0, 15));
        req_use_a = 1'($urandom_range(0, 1));  req_use_b = 1'($urandom_range(0, 1));
        for (int k = 1; k <= n; k++) begin
            check("rd_enable_read", 32'(rd_enable), 1);
            check("rd_addr_read", 32'(rd_addr), 32'((k == 1 && ua) ? sa : sb));
            check("op_valid_busy", 32'(op_valid), 0);
            check("req_ready_busy", 32'(req_ready), 0);
            set_wr(k, fk, fa, fd, rnd, sa, sb);
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            check("op_valid_hold", 32'(op_valid), 1);
            check("rd_enable_hold", 32'(rd_enable), 0);
            check("rd_addr_hold", 32'(rd_addr), 0);
            check("req_ready_hold", 32'(req_ready), 0);
            check("op_a", op_a, ua ? mem[sa] : 32'd0);
            check("op_b", op_b, ub ? mem[sb] : 32'd0);
            op_ready = (h == hold);
            set_wr(n + 1 + h, fk, fa, fd, rnd, sa, sb);
            tick();
        end
        op_ready  = 1'b0;
        wr_enable = 1'b0;
        check("req_ready_after", 32'(req_ready), 1);
        check("op_valid_after", 32'(op_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_src_a = '0; req_src_b = '0;
        req_use_a = 1'b0; req_use_b = 1'b0; wr_enable = 1'b0; wr_addr = '0;
        wr_data = '0; op_ready = 1'b0;
        tick(); tick();
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_rd_enable", 32'(rd_enable), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        rst = 1'b0;
        tick();

        // Two operands, plain reads.
        wr_reg(4'd3, 32'h11);
        wr_reg(4'd5, 32'h22);
        txn(4'd3, 4'd5, 1'b1, 1'b1, 2, 1'b0, -1, 4'd0, 32'd0);
        // Only B; a write to unused src_a during HOLD must be ignored.
        wr_reg(4'd7, 32'h5A);
        txn(4'd4, 4'd7, 1'b0, 1'b1, 2, 1'b0, 2, 4'd4, 32'hDEAD);
        // Bypass of a write in the READ_A cycle.
        wr_reg(4'd2, 32'h01);
        txn(4'd2, 4'd5, 1'b1, 1'b1, 1, 1'b0, 1, 4'd2, 32'h99);
        check("bypass_mem_r2", mem[2], 32'h99);
        // Snoop in HOLD, then an unrelated write in HOLD.
        txn(4'd3, 4'd5, 1'b1, 1'b1, 3, 1'b0, 3, 4'd5, 32'h77);
        txn(4'd3, 4'd5, 1'b1, 1'b1, 2, 1'b0, 3, 4'd9, 32'hABCD);
        // Snoop of op_a during READ_B, same source for both operands.
        txn(4'd6, 4'd6, 1'b1, 1'b1, 2, 1'b0, 2, 4'd6, 32'h1234);
        // Snoop in the op_ready cycle; consumer already took pre-write values.
        txn(4'd3, 4'd8, 1'b1, 1'b1, 0, 1'b0, 3, 4'd3, 32'h4444);
        // No operands: immediate HOLD, snoop ignored.
        txn(4'd1, 4'd2, 1'b0, 1'b0, 2, 1'b0, 1, 4'd1, 32'hFFFF);

        // Async reset while in READ_B.
        wr_reg(4'd3, 32'h11);
        req_valid = 1'b1; req_src_a = 4'd3; req_src_b = 4'd5; req_use_a = 1'b1; req_use_b = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_rd_addr", 32'(rd_addr), 5);
        rst = 1'b1;
        #1;
        check("arst_req_ready", 32'(req_ready), 1);
        check("arst_op_valid", 32'(op_valid), 0);
        check("arst_rd_enable", 32'(rd_enable), 0);
        check("arst_rd_addr", 32'(rd_addr), 0);
        check("arst_op_a", op_a, 0);
        check("arst_op_b", op_b, 0);
        tick();
        rst = 1'b0;
        tick();
        txn(4'd3, 4'd5, 1'b1, 1'b1, 1, 1'b0, -1, 4'd0, 32'd0);

        // Randomized transactions with random snooped writes.
        for (int t = 0; t < 200; t++) begin
            txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'b1, -1, 4'd0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
